// File: rtl/icache_pkg.sv
// icache_pkg: shared types and constants for the direct-mapped icache.
// FSM states, the fetch NOP and address-field helpers.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    RESPOND
  } state_t;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int XLEN = 32;
  localparam int BYTE_BITS = 2;

  function automatic int idx_lsb(int words);
    return $clog2(words) + BYTE_BITS;
  endfunction

  function automatic int tag_lsb(int lines, int words);
    return $clog2(lines) + $clog2(words) + BYTE_BITS;
  endfunction

endpackage

// File: rtl/icache_if.sv
// icache_if: fetch request/response and memory refill signals.
// slave is the cache side, master is the fetch/memory side.
interface icache_if;

  logic        addr_ready;
  logic [31:0] addr;
  logic        cache_ack;
  logic [31:0] inst;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  addr_ready, addr, flush,
    input  mem_ack, mem_rdata,
    output cache_ack, inst,
    output mem_req, mem_addr
  );

  modport master (
    output addr_ready, addr, flush,
    output mem_ack, mem_rdata,
    input  cache_ack, inst,
    input  mem_req, mem_addr
  );

endinterface

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage, one async read port,
// one word write port plus tag/valid fill and flush-clear.
module icache_array #(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int TB    = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [$clog2(LINES)-1:0] rd_idx,
  input  logic [$clog2(WORDS)-1:0] rd_off,
  output logic                     rd_valid,
  output logic [TB-1:0]            rd_tag,
  output logic [31:0]              rd_word,
  input  logic                     wr_en,
  input  logic [$clog2(LINES)-1:0] wr_idx,
  input  logic [$clog2(WORDS)-1:0] wr_off,
  input  logic [31:0]              wr_word,
  input  logic                     fill_en,
  input  logic [TB-1:0]            fill_tag,
  input  logic                     fill_valid
);

  logic [LINES-1:0] valid;
  logic [TB-1:0]    tags [LINES];
  logic [31:0]      data [LINES][WORDS];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_word  = data[rd_idx][rd_off];

  // flush outranks a same-edge fill so a flushed refill never goes valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[wr_idx] <= fill_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) tags[wr_idx] <= fill_tag;
    if (wr_en) data[wr_idx][wr_off] <= wr_word;
  end

endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only icache, zero-latency hits,
// in-order word refill on miss followed by one registered response.
module icache_direct
  import icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic   clk,
  input  logic   rst,
  icache_if.slave bus
);

  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int IL = idx_lsb(WORDS);
  localparam int TL = tag_lsb(LINES, WORDS);
  localparam int TB = XLEN - TL;
  localparam logic [OB-1:0] LAST = OB'(WORDS - 1);

  state_t state, next;
  logic [XLEN-1:BYTE_BITS] req;
  logic [OB-1:0] beat;
  logic          drop;

  logic [OB-1:0] a_off, r_off, rd_off;
  logic [IB-1:0] a_idx, r_idx, rd_idx;
  logic [TB-1:0] a_tag, r_tag, rd_tag;
  logic          rd_valid, hit, wr_en, fill_en;
  logic [31:0]   rd_word;

  assign a_off = bus.addr[IL-1:BYTE_BITS];
  assign a_idx = bus.addr[TL-1:IL];
  assign a_tag = bus.addr[XLEN-1:TL];
  assign r_off = req[IL-1:BYTE_BITS];
  assign r_idx = req[TL-1:IL];
  assign r_tag = req[XLEN-1:TL];

  assign rd_idx = (state == IDLE) ? a_idx : r_idx;
  assign rd_off = (state == IDLE) ? a_off : r_off;
  assign hit    = rd_valid && (rd_tag == a_tag);

  icache_array #(
    .LINES(LINES),
    .WORDS(WORDS),
    .TB   (TB)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .rd_idx    (rd_idx),
    .rd_off    (rd_off),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_word   (rd_word),
    .wr_en     (wr_en),
    .wr_idx    (r_idx),
    .wr_off    (beat),
    .wr_word   (bus.mem_rdata),
    .fill_en   (fill_en),
    .fill_tag  (r_tag),
    .fill_valid(!drop)
  );

  always_comb begin
    next          = state;
    bus.cache_ack = 1'b0;
    bus.inst      = '0;
    bus.mem_req   = 1'b0;
    bus.mem_addr  = {req[XLEN-1:IL], beat, 2'b00};
    wr_en         = 1'b0;
    fill_en       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.addr_ready) begin
          if (hit) begin
            bus.cache_ack = 1'b1;
            bus.inst      = rd_word;
          end else begin
            next = REFILL;
          end
        end
      end
      REFILL: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          wr_en = 1'b1;
          if (beat == LAST) begin
            fill_en = 1'b1;
            next    = RESPOND;
          end
        end
      end
      RESPOND: begin
        bus.cache_ack = 1'b1;
        bus.inst      = rd_word;
        next          = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      req   <= '0;
      beat  <= '0;
      drop  <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && bus.addr_ready && !hit) begin
        req  <= bus.addr[XLEN-1:BYTE_BITS];
        beat <= '0;
      end else if (wr_en) begin
        beat <= beat + OB'(1);
      end
      if (state == RESPOND) begin
        drop <= 1'b0;
      end else if (state == REFILL && bus.flush) begin
        drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: scoreboard bench for icache_direct with a
// memory model returning mem_addr ^ 32'hDEAD0000.
module tb_icache_direct;

  logic clk = 1'b0;
  logic rst = 1'b0;

  icache_if bus ();

  icache_direct #(
    .LINES(16),
    .WORDS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int nvec    = 0;
  int nerr    = 0;
  int cyc     = 0;
  int acks    = 0;
  int ack_cyc = 0;
  int wait_n  = 0;
  int n0      = 0;
  int t0      = 0;

  logic [31:0] sb[$];
  logic [31:0] beats[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #2;
    if (bus.cache_ack === 1'b1) begin
      acks++;
      ack_cyc = cyc;
      if (sb.size() == 0) chk("spurious_ack", 32'd1, 32'd0);
      else chk("inst", bus.inst, sb.pop_front());
    end
  end

  // memory: wait_n idle cycles before each beat's ack
  initial begin
    int w;
    w = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (rst && bus.mem_req) begin
        if (w >= wait_n) begin
          w             = 0;
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = bus.mem_addr ^ 32'hDEAD0000;
          beats.push_back(bus.mem_addr);
        end else begin
          w++;
        end
      end else begin
        w = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] exp,
                       input logic fl = 1'b0);
    @(negedge clk);
    beats.delete();
    n0 = acks;
    t0 = cyc;
    bus.addr_ready = 1'b1;
    bus.addr       = a;
    bus.flush      = fl;
    sb.push_back(exp);
    @(negedge clk);
    bus.addr_ready = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic wait_ack(input string tag, input int lat);
    int i;
    i = 0;
    while (acks == n0 && i < 100) begin
      @(negedge clk);
      #3;
      i++;
    end
    chk({tag, "_ack"}, 32'(acks - n0), 32'd1);
    chk({tag, "_lat"}, 32'(ack_cyc - t0), 32'(lat));
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp,
                       input int lat, input string tag);
    issue(a, exp);
    wait_ack(tag, lat);
  endtask

  task automatic wait_beats(input int n);
    int i;
    i = 0;
    #3;
    while (beats.size() < n && i < 100) begin
      @(negedge clk);
      #3;
      i++;
    end
    chk("beats_seen", 32'(beats.size() >= n), 32'd1);
  endtask

  function automatic logic [31:0] beat_at(input int i);
    return (i < beats.size()) ? beats[i] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int bad;
    bus.addr_ready = 1'b0;
    bus.addr       = '0;
    bus.flush      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ack", 32'(bus.cache_ack), 32'd0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    rst = 1'b1;

    fetch(32'h44, 32'hDEAD0044, 5, "cold");
    chk("cold_nbeats", 32'(beats.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("cold_maddr", beat_at(i), 32'h40 + 32'(4 * i));

    fetch(32'h4C, 32'hDEAD004C, 0, "hit");
    chk("hit_nomem", 32'(beats.size()), 32'd0);

    fetch(32'h1040, 32'hDEAD1040, 5, "conf");
    chk("conf_maddr", beat_at(0), 32'h1040);
    fetch(32'h40, 32'hDEAD0040, 5, "conf_back");

    wait_n = 3;
    issue(32'h80, 32'hDEAD0080);
    repeat (2) @(negedge clk);
    bus.addr_ready = 1'b1;
    bus.addr       = 32'h100;
    @(negedge clk);
    bus.addr_ready = 1'b0;
    wait_ack("busy", 17);
    bad = 0;
    foreach (beats[i]) if (beats[i][31:4] == 28'h10) bad++;
    chk("busy_no100", 32'(bad), 32'd0);
    chk("busy_nbeats", 32'(beats.size()), 32'd4);
    repeat (5) @(negedge clk);
    #3;
    chk("busy_oneack", 32'(acks - n0), 32'd1);
    wait_n = 0;

    issue(32'h200, 32'hDEAD0200);
    wait_beats(3);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    wait_ack("flush", 5);
    fetch(32'h200, 32'hDEAD0200, 5, "flush_again");
    fetch(32'h40, 32'hDEAD0040, 5, "flush_old");

    issue(32'h300, 32'hDEAD0300);
    wait_beats(2);
    @(posedge clk);
    #2;
    chk("rr_req_pre", 32'(bus.mem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("rr_req", 32'(bus.mem_req), 32'd0);
    chk("rr_ack", 32'(bus.cache_ack), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    fetch(32'h300, 32'hDEAD0300, 5, "rr_again");
    chk("rr_nbeats", 32'(beats.size()), 32'd4);
    fetch(32'h308, 32'hDEAD0308, 0, "rr_hit");

    issue(32'h304, 32'hDEAD0304, 1'b1);
    wait_ack("fidle", 0);
    fetch(32'h304, 32'hDEAD0304, 5, "fidle_miss");

    repeat (3) @(negedge clk);
    #3;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
